// File: rtl/llm_outlier_pkg.sv
// Shared fp16 field positions, outlier threshold and FSM state type
// for the outlier splitter datapath.
package llm_outlier_pkg;

    localparam int FP16_W  = 16;
    localparam int EXP_MSB = 14;
    localparam int EXP_LSB = 10;

    // Biased exponent 18 corresponds to |x| >= 8.0; Inf/NaN (31) also qualify.
    localparam logic [EXP_MSB-EXP_LSB:0] OUTLIER_EXP_MIN = 5'd18;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/fp16_outlier_flag.sv
// Combinational per-element outlier detector: flags |x| >= 8.0 from the
// exponent field alone, so sign, zeros and subnormals never flag.
module fp16_outlier_flag
    import llm_outlier_pkg::*;
(
    input  logic [FP16_W-1:0] fp,
    output logic              flag
);

    logic w_unused;

    assign flag     = (fp[EXP_MSB:EXP_LSB] >= OUTLIER_EXP_MIN);
    assign w_unused = ^{fp[FP16_W-1], fp[EXP_LSB-1:0]};

endmodule

// File: rtl/fp16_outlier_splitter.sv
// Buffers one tile of fp16 beats, builds a per-column outlier mask, then
// replays the tile as column-masked high- and low-precision streams.
//
//   state | meaning
//   FILL  | accepting input beats into buffer, accumulating column mask
//   DRAIN | replaying buffered rows on hi/lo outputs, input stalled
module fp16_outlier_splitter
    import llm_outlier_pkg::*;
#(
    parameter int PARALLELISM = 4,
    parameter int ROWS        = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PARALLELISM*FP16_W-1:0] data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic [PARALLELISM*FP16_W-1:0] data_out_hi,
    output logic [PARALLELISM*FP16_W-1:0] data_out_lo,
    output logic [PARALLELISM-1:0]        outlier_mask,
    output logic                          data_out_valid,
    input  logic                          data_out_ready
);

    localparam int               DW       = PARALLELISM * FP16_W;
    localparam int               CW       = $clog2(ROWS);
    localparam logic [CW-1:0]    LAST_ROW = CW'(ROWS - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [CW-1:0]           r_wr_cnt;
    logic [CW-1:0]           r_rd_cnt;
    logic [PARALLELISM-1:0]  r_mask;
    logic [PARALLELISM-1:0]  w_flags;
    logic [DW-1:0]           r_buf [ROWS];
    logic [DW-1:0]           w_row;
    logic                    w_in_hs;
    logic                    w_out_hs;
    logic                    w_drain;

    genvar c;
    generate
        for (c = 0; c < PARALLELISM; c++) begin : g_flag
            fp16_outlier_flag u_flag (
                .fp   (data_in[c*FP16_W +: FP16_W]),
                .flag (w_flags[c])
            );
        end
    endgenerate

    assign data_in_ready  = (r_state == FILL);
    assign data_out_valid = (r_state == DRAIN);
    assign w_drain        = data_out_valid;
    assign w_in_hs        = data_in_valid && data_in_ready;
    assign w_out_hs       = data_out_valid && data_out_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_in_hs && (r_wr_cnt == LAST_ROW)) w_state_nxt = DRAIN;
            DRAIN:   if (w_out_hs && (r_rd_cnt == LAST_ROW)) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FILL;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_mask   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_hs) begin
                // First beat restarts the mask so no bits leak across tiles.
                r_mask   <= (r_wr_cnt == '0) ? w_flags : (r_mask | w_flags);
                r_wr_cnt <= (r_wr_cnt == LAST_ROW) ? '0 : r_wr_cnt + CNT_ONE;
            end
            if (w_out_hs) begin
                r_rd_cnt <= (r_rd_cnt == LAST_ROW) ? '0 : r_rd_cnt + CNT_ONE;
            end
        end
    end

    // Tile storage is intentionally unreset; rows are always written before read.
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_buf[r_wr_cnt] <= data_in;
        end
    end

    assign w_row        = r_buf[r_rd_cnt];
    assign outlier_mask = w_drain ? r_mask : '0;

    generate
        for (c = 0; c < PARALLELISM; c++) begin : g_split
            assign data_out_hi[c*FP16_W +: FP16_W] =
                (w_drain && r_mask[c])  ? w_row[c*FP16_W +: FP16_W] : '0;
            assign data_out_lo[c*FP16_W +: FP16_W] =
                (w_drain && !r_mask[c]) ? w_row[c*FP16_W +: FP16_W] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_fp16_outlier_splitter.sv
// Scoreboard bench for fp16_outlier_splitter: directed tiles with hand-derived
// column masks; a negedge monitor checks every output beat in order.
module tb_fp16_outlier_splitter;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        logic [3:0]  m;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [63:0] data_out_hi;
    logic [63:0] data_out_lo;
    logic [3:0]  outlier_mask;
    logic        data_out_valid;
    logic        data_out_ready;

    int    errors = 0;
    int    checks = 0;
    exp_t  sb[$];
    time   in_times[$];
    time   out_times[$];

    fp16_outlier_splitter #(.PARALLELISM(4), .ROWS(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out_hi    (data_out_hi),
        .data_out_lo    (data_out_lo),
        .outlier_mask   (outlier_mask),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] sel(input logic [63:0] row, input logic [3:0] m, input bit hi);
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            if (m[c] == hi) r[c*16 +: 16] = row[c*16 +: 16];
        return r;
    endfunction

    // Monitor: every accepted output beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && data_out_valid && data_out_ready) begin
            out_times.push_back($time + 5);
            check("in_ready_low_in_drain", {63'd0, data_in_ready}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hi", data_out_hi, e.hi);
                check("lo", data_out_lo, e.lo);
                check("mask", {60'd0, outlier_mask}, {60'd0, e.m});
            end
        end
    end

    task automatic send_tile(input logic [63:0] rows [4], input logic [3:0] m, input bit keep_valid);
        int n;
        for (int r = 0; r < 4; r++) begin
            exp_t e;
            e.hi = sel(rows[r], m, 1'b1);
            e.lo = sel(rows[r], m, 1'b0);
            e.m  = m;
            sb.push_back(e);
        end
        for (int r = 0; r < 4; r++) begin
            data_in       = rows[r];
            data_in_valid = 1'b1;
            n = 0;
            @(posedge clk);
            while (!data_in_ready && n < 50) begin
                @(posedge clk);
                n++;
            end
            if (n >= 50) check("in_handshake_timeout", 64'd1, 64'd0);
            in_times.push_back($time);
            #1;
        end
        if (!keep_valid) data_in_valid = 1'b0;
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", {63'd0, (sb.size() != 0)}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [63:0] t_thr   [4];
    logic [63:0] t_spec  [4];
    logic [63:0] t_a     [4];
    logic [63:0] t_b     [4];
    logic [63:0] t_bp    [4];
    logic [63:0] t_rst   [4];
    logic [63:0] t_post  [4];

    initial begin
        logic [63:0] h_hold, l_hold;
        logic [3:0]  m_hold;
        int n;

        // element c at [16c+15:16c] => literal order {c3,c2,c1,c0}
        t_thr  = '{{16'h0000, 16'hC800, 16'h47FF, 16'h4800}, {4{16'h3C00}}, {4{16'h3C00}}, {4{16'h3C00}}};
        t_spec = '{{16'h7E00, 16'h8000, 16'h7C00, 16'h03FF}, {4{16'h0001}}, {4{16'hBC00}}, {4{16'h0001}}};
        t_a    = '{{4{16'h3C00}}, {4{16'h3C00}}, {16'hD000, 16'h3C00, 16'h3C00, 16'h3C00}, {4{16'h3C00}}};
        t_b    = '{{16'h4400, 16'hC7FF, 16'h0000, 16'h3C00}, {16'h47FF, 16'h4400, 16'h8000, 16'h0200},
                   {4{16'h4000}}, {16'hC400, 16'h3800, 16'h4500, 16'h4600}};
        t_bp   = '{{16'hFC00, 16'h3C00, 16'h1000, 16'h5000}, {16'hFC00, 16'h3C00, 16'h1001, 16'h5001},
                   {16'hFC00, 16'h3C00, 16'h1002, 16'h5002}, {16'hFC00, 16'h3C00, 16'h1003, 16'h5003}};
        t_rst  = '{{16'h6400, 16'h0002, 16'h6000, 16'h0001}, {4{16'h1111}}, {4{16'h2222}}, {4{16'h3333}}};
        t_post = '{{4{16'h0100}}, {16'h0000, 16'h0000, 16'h0000, 16'h4800}, {4{16'h0200}}, {4{16'h0300}}};

        rst_n = 1'b0;
        data_in = '0;
        data_in_valid = 1'b0;
        data_out_ready = 1'b1;
        #1;
        check("rst_in_ready", {63'd0, data_in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, data_out_valid}, 64'd0);
        check("rst_mask", {60'd0, outlier_mask}, 64'd0);
        check("rst_hi", data_out_hi, 64'd0);
        check("rst_lo", data_out_lo, 64'd0);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;

        // Threshold edges: 8.0 and -8.0 flag, 7.996 and 0 do not.
        send_tile(t_thr, 4'b0101, 1'b0);
        wait_drained();

        // Inf/NaN flag; subnormal and -0 do not.
        send_tile(t_spec, 4'b1010, 1'b0);
        wait_drained();

        // Mask must restart on each tile.
        send_tile(t_a, 4'b1000, 1'b0);
        wait_drained();
        send_tile(t_b, 4'b0000, 1'b0);
        wait_drained();

        // Backpressure on row 1 for 5 cycles.
        send_tile(t_bp, 4'b1001, 1'b0);
        @(posedge clk); #1;
        data_out_ready = 1'b0;
        @(negedge clk);
        h_hold = data_out_hi;
        l_hold = data_out_lo;
        m_hold = outlier_mask;
        check("bp_row1_hi", h_hold, 64'hFC00_0000_0000_5001);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hi_stable", data_out_hi, h_hold);
            check("bp_lo_stable", data_out_lo, l_hold);
            check("bp_mask_stable", {60'd0, outlier_mask}, {60'd0, m_hold});
            check("bp_valid", {63'd0, data_out_valid}, 64'd1);
            check("bp_in_ready", {63'd0, data_in_ready}, 64'd0);
        end
        @(posedge clk); #1;
        data_out_ready = 1'b1;
        wait_drained();
        check("bp_fill_resumes", {62'd0, data_in_ready, data_out_valid}, 64'd2);

        // Latency/throughput with continuous valid and ready.
        in_times.delete();
        out_times.delete();
        send_tile(t_thr, 4'b0101, 1'b1);
        send_tile(t_spec, 4'b1010, 1'b0);
        wait_drained();
        for (int k = 0; k < 4; k++) begin
            check("lat_out_edge", 64'(out_times[k] - in_times[0]), 64'(10 * (4 + k)));
            check("thr_in_edge", 64'(in_times[4 + k] - in_times[0]), 64'(10 * (4 + k)) + 64'd40);
        end

        // Async reset mid-drain after row 1 has been accepted.
        send_tile(t_rst, 4'b1010, 1'b0);
        n = 0;
        while (sb.size() != 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_wait_rows", {63'd0, (n >= 50)}, 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, data_out_valid}, 64'd0);
        check("mid_rst_mask", {60'd0, outlier_mask}, 64'd0);
        check("mid_rst_in_ready", {63'd0, data_in_ready}, 64'd1);
        check("mid_rst_hi", data_out_hi, 64'd0);
        sb.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send_tile(t_post, 4'b0001, 1'b0);
        wait_drained();
        check("post_rst_idle", {62'd0, data_in_ready, data_out_valid}, 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
